ospi_req_arbiter: RTL and testbench

- Two-requester arbiter and access sequencer for the ospi_flash memory-operation interface.
- Each requester posts one read, write or erase transaction. The block arbitrates round-robin, frames the access with chip select, and drives the enable/address/data strobes for a fixed number of cycles.
- Read data is captured and returned to the winning requester with a one-cycle done pulse.
- Sits between host-side masters (e.g. CPU port and DMA port) and the flash model/PHY.

---
 rtl/ospi_req_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_ospi_req_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ospi_req_arbiter.sv
// Two-requester round-robin arbiter and access sequencer for the ospi_flash
// memory-operation interface. The winner's read, write or erase is framed with
// chip select, and the strobes are timed by one shared down-counter. All
// outputs are registered.
module ospi_req_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int SETUP_CYC  = 1,
    parameter int ACCESS_CYC = 1,
    parameter int ERASE_CYC  = 4,
    parameter int READ_LAT   = 1,
    parameter int HOLD_CYC   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req,
    input  logic [1:0]        op0,
    input  logic [1:0]        op1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        gnt,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              ospi_cs,
    output logic              read_enable,
    output logic              write_enable,
    output logic              erase_enable,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] data_out
);

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_ERASE = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    // The counter only ever holds N-1 for the longest phase.
    localparam int MAX_A   = (SETUP_CYC > ACCESS_CYC) ? SETUP_CYC : ACCESS_CYC;
    localparam int MAX_B   = (ERASE_CYC > READ_LAT) ? ERASE_CYC : READ_LAT;
    localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_CYC = (MAX_C > HOLD_CYC) ? MAX_C : HOLD_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] ACCESS_LD = CNT_W'(ACCESS_CYC - 1);
    localparam logic [CNT_W-1:0] ERASE_LD  = CNT_W'(ERASE_CYC - 1);
    localparam logic [CNT_W-1:0] LAT_LD    = CNT_W'(READ_LAT - 1);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_WAIT,
        S_HOLD,
        S_DONE
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [1:0]         op_reg;
    logic               prio;      // requester that wins a tie next
    logic               served;    // requester owning the current transaction
    logic               win;
    logic [1:0]         win_op;
    logic [ADDR_W-1:0]  win_addr;
    logic [DATA_W-1:0]  win_wdata;

    // Winner selection: a lone requester wins, a tie goes to the priority pointer.
    always_comb begin
        win = 1'b0;
        case (req)
            2'b01:   win = 1'b0;
            2'b10:   win = 1'b1;
            2'b11:   win = prio;
            default: win = 1'b0;
        endcase
        win_op    = win ? op1 : op0;
        win_addr  = win ? addr1 : addr0;
        win_wdata = win ? wdata1 : wdata0;
    end

    // Sequencer: each transition also sets the registered outputs of the state entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            op_reg       <= OP_READ;
            prio         <= 1'b0;
            served       <= 1'b0;
            gnt          <= 2'b00;
            done         <= 1'b0;
            err          <= 1'b0;
            rdata        <= '0;
            busy         <= 1'b0;
            ospi_cs      <= 1'b1;
            read_enable  <= 1'b0;
            write_enable <= 1'b0;
            erase_enable <= 1'b0;
            address      <= '0;
            data_in      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|req) begin
                        op_reg  <= win_op;
                        address <= win_addr;
                        data_in <= win_wdata;
                        served  <= win;
                        gnt     <= win ? 2'b10 : 2'b01;
                        busy    <= 1'b1;
                        if (win_op == OP_RSVD) begin
                            // Reserved op never touches the flash.
                            state <= S_DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            state   <= S_SETUP;
                            ospi_cs <= 1'b0;
                            cnt     <= SETUP_LD;
                        end
                    end
                end
                S_SETUP: begin
                    if (cnt == '0) begin
                        state <= S_ACCESS;
                        case (op_reg)
                            OP_READ: begin
                                read_enable <= 1'b1;
                                cnt         <= ACCESS_LD;
                            end
                            OP_WRITE: begin
                                write_enable <= 1'b1;
                                cnt          <= ACCESS_LD;
                            end
                            default: begin
                                erase_enable <= 1'b1;
                                cnt          <= ERASE_LD;
                            end
                        endcase
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_ACCESS: begin
                    if (cnt == '0) begin
                        read_enable  <= 1'b0;
                        write_enable <= 1'b0;
                        erase_enable <= 1'b0;
                        if (op_reg == OP_READ) begin
                            state <= S_WAIT;
                            cnt   <= LAT_LD;
                        end else begin
                            state   <= S_HOLD;
                            ospi_cs <= 1'b1;
                            cnt     <= HOLD_LD;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_WAIT: begin
                    if (cnt == '0) begin
                        rdata   <= data_out;
                        state   <= S_HOLD;
                        ospi_cs <= 1'b1;
                        cnt     <= HOLD_LD;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_HOLD: begin
                    if (cnt == '0) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    // Hand priority to the other requester; no grant in this cycle.
                    done  <= 1'b0;
                    err   <= 1'b0;
                    gnt   <= 2'b00;
                    busy  <= 1'b0;
                    prio  <= ~served;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ospi_req_arbiter.sv
// Directed bench for ospi_req_arbiter: read, write, contention, reserved,
// erase, mid-access reset and a stuck request, each checked with assertions.
module tb_ospi_req_arbiter;

    logic       clk;
    logic       reset;
    logic [1:0] req;
    logic [1:0] op0, op1;
    logic [7:0] addr0, addr1, wdata0, wdata1;
    logic [1:0] gnt;
    logic       done, err, busy, ospi_cs;
    logic       read_enable, write_enable, erase_enable;
    logic [7:0] rdata, address, data_in, data_out;

    int checks = 0;
    int errors = 0;

    // Per-transaction observations
    int         lat, cs_low_n, re_n, we_n, ee_n, overlap, en_cs_bad;
    logic [7:0] addr_at_en, din_at_en;
    logic [1:0] gnt_at_done;
    logic       err_at_done;

    ospi_req_arbiter dut (
        .clk(clk), .reset(reset), .req(req),
        .op0(op0), .op1(op1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt(gnt), .done(done), .err(err), .rdata(rdata), .busy(busy),
        .ospi_cs(ospi_cs), .read_enable(read_enable),
        .write_enable(write_enable), .erase_enable(erase_enable),
        .address(address), .data_in(data_in), .data_out(data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Follow one transaction from its selection edge to done (bounded).
    task automatic observe(input int maxc);
        bit got;
        got = 0;
        lat = -1; cs_low_n = 0; re_n = 0; we_n = 0; ee_n = 0;
        overlap = 0; en_cs_bad = 0;
        addr_at_en = 8'h00; din_at_en = 8'h00; gnt_at_done = 2'b00; err_at_done = 1'b0;
        for (int c = 1; c <= maxc && !got; c++) begin
            @(posedge clk); #1;
            if (!ospi_cs) cs_low_n++;
            if (read_enable) re_n++;
            if (write_enable) we_n++;
            if (erase_enable) ee_n++;
            if ((int'(read_enable) + int'(write_enable) + int'(erase_enable)) > 1) overlap++;
            if ((read_enable | write_enable | erase_enable) && ospi_cs) en_cs_bad++;
            if (read_enable | write_enable | erase_enable) begin
                addr_at_en = address;
                din_at_en  = data_in;
            end
            if (done) begin
                got = 1;
                lat = c;
                gnt_at_done = gnt;
                err_at_done = err;
            end
        end
        $display("txn: lat=%0d cs_low=%0d re=%0d we=%0d ee=%0d gnt=%b err=%b rdata=%h",
                 lat, cs_low_n, re_n, we_n, ee_n, gnt_at_done, err_at_done, rdata);
    endtask

    initial begin
        reset = 1'b1; req = 2'b00;
        op0 = 2'b00; op1 = 2'b00; addr0 = 8'h00; addr1 = 8'h00;
        wdata0 = 8'h00; wdata1 = 8'h00; data_out = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_cs", ospi_cs, 1);
        check("rst_gnt", gnt, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_rdata", rdata, 0);
        check("rst_addr", address, 0);
        check("rst_en", {read_enable, write_enable, erase_enable}, 0);
        reset = 1'b0;

        // Read by requester 0
        op0 = 2'b00; addr0 = 8'h01; data_out = 8'hA5; req = 2'b01;
        observe(20);
        req = 2'b00;
        check("rd_lat", lat, 6);
        check("rd_cs_low", cs_low_n, 3);
        check("rd_re_n", re_n, 1);
        check("rd_addr", addr_at_en, 8'h01);
        check("rd_rdata", rdata, 8'hA5);
        check("rd_err", err_at_done, 0);
        check("rd_gnt", gnt_at_done, 2'b01);
        @(posedge clk); #1;
        check("rd_idle_busy", busy, 0);
        check("rd_idle_gnt", gnt, 0);

        // Write by requester 1
        op1 = 2'b01; addr1 = 8'h10; wdata1 = 8'h3C; data_out = 8'hFF; req = 2'b10;
        observe(20);
        req = 2'b00;
        check("wr_lat", lat, 5);
        check("wr_we_n", we_n, 1);
        check("wr_re_n", re_n, 0);
        check("wr_din", din_at_en, 8'h3C);
        check("wr_addr", addr_at_en, 8'h10);
        check("wr_rdata_kept", rdata, 8'hA5);
        check("wr_gnt", gnt_at_done, 2'b10);
        @(posedge clk); #1;

        // Contention: both read, req held high
        op0 = 2'b00; addr0 = 8'h01; op1 = 2'b00; addr1 = 8'h20; data_out = 8'h5A;
        req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            observe(20);
            check("ct_gnt", gnt_at_done, (k % 2 == 0) ? 2'b01 : 2'b10);
            check("ct_lat", lat, 6);
            check("ct_overlap", overlap, 0);
            check("ct_en_cs", en_cs_bad, 0);
            check("ct_addr", addr_at_en, (k % 2 == 0) ? 8'h01 : 8'h20);
            @(posedge clk); #1;
            check("ct_idle_busy", busy, 0);
            check("ct_idle_gnt", gnt, 0);
        end
        req = 2'b00;
        @(posedge clk); #1;

        // Reserved op by requester 1
        op1 = 2'b11; req = 2'b10;
        observe(20);
        req = 2'b00;
        check("rs_lat", lat, 1);
        check("rs_err", err_at_done, 1);
        check("rs_cs_low", cs_low_n, 0);
        check("rs_gnt", gnt_at_done, 2'b10);
        @(posedge clk); #1;
        check("rs_err_clear", err, 0);

        // Erase by requester 0 (leaves priority with requester 1)
        op0 = 2'b10; addr0 = 8'h40; req = 2'b01;
        observe(20);
        req = 2'b00;
        check("er_ee_n", ee_n, 4);
        check("er_lat", lat, 8);
        check("er_err", err_at_done, 0);
        check("er_addr", addr_at_en, 8'h40);
        @(posedge clk); #1;

        // Write by requester 0, reset during ACCESS
        op0 = 2'b01; addr0 = 8'h33; wdata0 = 8'h77; req = 2'b01;
        @(posedge clk); #1;
        check("ab_setup_cs", ospi_cs, 0);
        @(posedge clk); #1;
        check("ab_access_we", write_enable, 1);
        req = 2'b00;
        reset = 1'b1;
        #1;
        check("ab_cs", ospi_cs, 1);
        check("ab_we", write_enable, 0);
        check("ab_gnt", gnt, 0);
        #2 reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("ab_no_done", done, 0);
        end

        // Both request after reset: requester 0 must win
        op0 = 2'b00; addr0 = 8'h44; op1 = 2'b00; addr1 = 8'h55; data_out = 8'hC3;
        req = 2'b11;
        observe(20);
        req = 2'b01;
        check("pr_gnt", gnt_at_done, 2'b01);
        check("pr_addr", addr_at_en, 8'h44);
        check("pr_rdata", rdata, 8'hC3);

        // Stuck request: requester 0 keeps req high
        data_out = 8'h96;
        @(posedge clk); #1;
        check("st_idle_busy", busy, 0);
        observe(20);
        req = 2'b00;
        check("st_lat", lat, 6);
        check("st_gnt", gnt_at_done, 2'b01);
        check("st_addr", addr_at_en, 8'h44);
        check("st_rdata", rdata, 8'h96);
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
